// File: rtl/ff_pkg.sv
// Shared definitions for the flop readback/loader pair: FSM states and parity sense.
package ff_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        PAR   = 2'd2
    } ff_state_e;

    localparam logic PARITY_EVEN = 1'b1;

    // Parity bit that makes data plus parity carry an even (or odd) count of ones.
    function automatic logic frame_parity(input logic data_xor, input logic even);
        return even ? data_xor : ~data_xor;
    endfunction

endpackage

// File: rtl/ff_shadow_sreg.sv
// Shadow register: parallel snapshot load, then shift right exposing the LSB.
module ff_shadow_sreg #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             load_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             shift_i,
    output logic             lsb_o
);

    logic [WIDTH-1:0] shadow_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            shadow_q <= '0;
        end else if (load_i) begin
            shadow_q <= data_i;
        end else if (shift_i) begin
            shadow_q <= {1'b0, shadow_q[WIDTH-1:1]};
        end
    end

    assign lsb_o = shadow_q[0];

endmodule

// File: rtl/ff_readback.sv
// Serial readback engine: snapshots a flop vector and streams it LSB-first plus parity.
module ff_readback
    import ff_pkg::*;
#(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned CW    = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             L,
    input  logic             cap,
    input  logic [WIDTH-1:0] din,
    output logic             sout,
    output logic             sout_valid,
    input  logic             sout_ready,
    output logic             sout_last,
    output logic             busy,
    output logic             done,
    output logic             overrun
);

    ff_state_e   state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic        par_q, par_d;
    logic        done_q, done_d;
    logic        ovr_q, ovr_d;
    logic        load, shift, sh_lsb;

    ff_shadow_sreg #(
        .WIDTH(WIDTH)
    ) u_shadow (
        .clk_i  (clk),
        .rst_ni (L),
        .load_i (load),
        .data_i (din),
        .shift_i(shift),
        .lsb_o  (sh_lsb)
    );

    always_ff @(posedge clk or negedge L) begin
        if (!L) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            par_q   <= 1'b0;
            done_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            par_q   <= par_d;
            done_q  <= done_d;
            ovr_q   <= ovr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        par_d   = par_q;
        done_d  = 1'b0;
        ovr_d   = ovr_q;
        load    = 1'b0;
        shift   = 1'b0;
        case (state_q)
            IDLE: begin
                if (cap) begin
                    load    = 1'b1;
                    par_d   = frame_parity(^din, PARITY_EVEN);
                    cnt_d   = '0;
                    ovr_d   = 1'b0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (cap) ovr_d = 1'b1;
                if (sout_ready) begin
                    shift = 1'b1;
                    // Counter parks at WIDTH-1 on the last data bit rather than wrapping.
                    if (cnt_q == CW'(WIDTH - 1)) begin
                        state_d = PAR;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            PAR: begin
                if (cap) ovr_d = 1'b1;
                if (sout_ready) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign sout_valid = (state_q != IDLE);
    assign sout_last  = (state_q == PAR);
    assign sout       = (state_q == SHIFT) ? sh_lsb :
                        (state_q == PAR)   ? par_q  : 1'b0;
    assign busy       = sout_valid;
    assign done       = done_q;
    assign overrun    = ovr_q;

endmodule

// File: tb/tb_ff_readback.sv
// Randomized bench for ff_readback against a queue-based frame model.
module tb_ff_readback;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         L = 1'b0;
    logic         cap = 1'b0;
    logic         sout_ready = 1'b0;
    logic [W-1:0] din = '0;
    logic         sout, sout_valid, sout_last, busy, done, overrun;

    always #5 clk = ~clk;

    ff_readback #(.WIDTH(W)) dut (
        .clk       (clk),
        .L         (L),
        .cap       (cap),
        .din       (din),
        .sout      (sout),
        .sout_valid(sout_valid),
        .sout_ready(sout_ready),
        .sout_last (sout_last),
        .busy      (busy),
        .done      (done),
        .overrun   (overrun)
    );

    int checks = 0;
    int errors = 0;

    // Model: a frame is just a queue of bits still to be delivered.
    bit         m_busy = 1'b0;
    bit         m_done = 1'b0;
    bit         m_ovr  = 1'b0;
    bit         mq[$];
    logic [W:0] mlog = '0;
    int         mlog_n = 0;

    int busy_cycles = 0, done_pulses = 0;
    bit gap_mode = 1'b0, prev_busy = 1'b0;
    int gap_bad = 0, frames_seen = 0, idle_len = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        bit b;
        if (!m_busy) begin
            m_done = 1'b0;
            if (cap) begin
                mq.delete();
                for (int i = 0; i < W; i++) mq.push_back(din[i]);
                mq.push_back(^din);
                m_busy = 1'b1;
                m_ovr  = 1'b0;
            end
        end else begin
            m_done = 1'b0;
            if (cap) m_ovr = 1'b1;
            if (sout_ready) begin
                b = mq.pop_front();
                if (mlog_n <= W) mlog[mlog_n] = b;
                mlog_n++;
                if (mq.size() == 0) begin
                    m_busy = 1'b0;
                    m_done = 1'b1;
                end
            end
        end
    endtask

    initial forever begin
        @(posedge clk or negedge L);
        if (!L) begin
            m_busy = 1'b0;
            m_done = 1'b0;
            m_ovr  = 1'b0;
            mq.delete();
        end else begin
            model_step();
        end
    end

    initial forever begin
        logic es, el;
        @(negedge clk);
        es = 1'b0;
        el = 1'b0;
        if (m_busy && mq.size() > 0) begin
            es = mq[0];
            el = (mq.size() == 1);
        end
        chk("sout_valid", 32'(sout_valid), 32'(m_busy));
        chk("busy",       32'(busy),       32'(m_busy));
        chk("sout",       32'(sout),       32'(es));
        chk("sout_last",  32'(sout_last),  32'(el));
        chk("done",       32'(done),       32'(m_done));
        chk("overrun",    32'(overrun),    32'(m_ovr));
        if (busy) busy_cycles++;
        if (done) done_pulses++;
        if (gap_mode) begin
            if (busy && !prev_busy) begin
                if (frames_seen > 0 && idle_len != 1) gap_bad++;
                frames_seen++;
                idle_len = 0;
            end else if (!busy) begin
                idle_len++;
            end
        end
        prev_busy = busy;
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic start_frame(input logic [W-1:0] d);
        din = d;
        cap = 1'b1;
        @(negedge clk);
        cap = 1'b0;
    endtask

    task automatic wait_idle(input int budget, input string name);
        int n = 0;
        while ((m_busy || busy) && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (n >= budget) begin
            checks++;
            errors++;
            $display("FAIL %s timeout busy=%0b expected=0", name, busy);
        end
    endtask

    task automatic chk_zero_outputs(input string tag);
        chk({tag, "_sout"},       32'(sout),       0);
        chk({tag, "_sout_valid"}, 32'(sout_valid), 0);
        chk({tag, "_sout_last"},  32'(sout_last),  0);
        chk({tag, "_busy"},       32'(busy),       0);
        chk({tag, "_done"},       32'(done),       0);
        chk({tag, "_overrun"},    32'(overrun),    0);
    endtask

    initial begin
        logic [W-1:0] d;
        int n;

        cyc(3);
        chk_zero_outputs("reset");
        L = 1'b1;
        cyc(1);

        // Basic frame, sink always ready
        sout_ready = 1'b1;
        mlog_n = 0; busy_cycles = 0; done_pulses = 0;
        start_frame(8'hA5);
        wait_idle(40, "t1_wait");
        cyc(2);
        chk("t1_bits",        32'(mlog),   32'({1'b0, 8'hA5}));
        chk("t1_count",       32'(mlog_n), 9);
        chk("t1_busy_cycles", 32'(busy_cycles), 9);
        chk("t1_done_pulses", 32'(done_pulses), 1);

        // Snapshot frozen against din changes
        mlog_n = 0;
        start_frame(8'h01);
        cyc(3);
        din = 8'hFF;
        wait_idle(40, "t2_wait");
        cyc(2);
        chk("t2_bits", 32'(mlog), 32'({1'b1, 8'h01}));

        // Random backpressure
        mlog_n = 0;
        sout_ready = 1'b0;
        start_frame(8'hA5);
        n = 0;
        while (m_busy && n < 400) begin
            sout_ready = ($urandom_range(0, 1) != 0);
            @(negedge clk);
            n++;
        end
        if (n >= 400) begin
            checks++; errors++;
            $display("FAIL t3_wait timeout busy=%0b expected=0", busy);
        end
        sout_ready = 1'b1;
        cyc(2);
        chk("t3_bits",  32'(mlog),   32'({1'b0, 8'hA5}));
        chk("t3_count", 32'(mlog_n), 9);

        // Capture during a frame sets overrun only
        mlog_n = 0;
        start_frame(8'h3C);
        cyc(2);
        din = 8'hFF;
        cap = 1'b1;
        @(negedge clk);
        cap = 1'b0;
        wait_idle(40, "t4_wait");
        cyc(1);
        chk("t4_bits",    32'(mlog),    32'({1'b0, 8'h3C}));
        chk("t4_overrun", 32'(overrun), 1);
        start_frame(8'h5A);
        chk("t4_ovr_clear", 32'(overrun), 0);
        wait_idle(40, "t4b_wait");
        cyc(1);

        // Asynchronous reset mid-frame
        done_pulses = 0;
        start_frame(8'hC3);
        cyc(4);
        #2 L = 1'b0;
        #1 chk_zero_outputs("t5_rst");
        @(negedge clk);
        L = 1'b1;
        cyc(2);
        chk("t5_no_done", 32'(done_pulses), 0);
        mlog_n = 0;
        d = W'($urandom);
        start_frame(d);
        wait_idle(40, "t5_wait");
        cyc(1);
        chk("t5_bits", 32'(mlog), 32'({^d, d}));

        // cap held high: back-to-back frames with a single idle cycle between
        idle_len = 0; frames_seen = 0; gap_bad = 0; prev_busy = 1'b0;
        gap_mode = 1'b1;
        cap = 1'b1;
        repeat (45) begin
            @(negedge clk);
            din = W'($urandom);
        end
        chk("t6_overrun", 32'(overrun), 1);
        cap = 1'b0;
        wait_idle(40, "t6_wait");
        gap_mode = 1'b0;
        chk("t6_gap_bad", 32'(gap_bad), 0);
        chk("t6_frames",  32'(frames_seen), 5);

        // Fully random traffic with occasional resets
        repeat (400) begin
            cap        = ($urandom_range(0, 7) == 0);
            din        = W'($urandom);
            sout_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 150) == 0) begin
                #2 L = 1'b0;
                #1;
                @(negedge clk);
                L = 1'b1;
            end else begin
                @(negedge clk);
            end
        end
        cap = 1'b0;
        sout_ready = 1'b1;
        wait_idle(60, "rand_wait");
        cyc(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/ff_readback.md
# ff_readback

Serial readback engine for a bank of state flops. On a capture request it snapshots a WIDTH-bit parallel vector of flop Q values into a shadow register. It then shifts the snapshot out LSB-first over a valid/ready serial port, followed by one even-parity bit. It is the read-side counterpart of the flop models: those write state into flops, and this block reads that state back out for equivalence checking and debug of mapped netlists.

## Interface
Parameters:
- WIDTH, 16, number of flop bits captured per frame (≥2).
- CW, $clog2(WIDTH), bit counter width (derived; do not override).

Ports:
- clk  in  1  single clock; all state updates on posedge clk.
- L  in  1  reset, asynchronous, active-low.
- cap  in  1  capture request; sampled every cycle.
- din  in  WIDTH  parallel flop Q values to snapshot.
- sout  out  1  serial data bit.
- sout_valid  out  1  sout holds a valid bit.
- sout_ready  in  1  sink accepts the bit on the current edge when sout_valid=1.
- sout_last  out  1  current bit is the parity bit, i.e. the last bit of the frame.
- busy  out  1  frame in progress (state ≠ IDLE).
- done  out  1  one-cycle pulse after the parity bit is accepted.
- overrun  out  1  sticky; set when cap=1 is seen while busy.

## Operation
- States: IDLE, SHIFT, PAR.
- IDLE:
  - On cap=1: shadow ← din; par ← ^din; cnt ← 0; overrun ← 0; go to SHIFT.
  - Otherwise hold.
- SHIFT:
  - Drive sout_valid=1, sout=shadow[0], sout_last=0.
  - On sout_valid&sout_ready: shadow ← shadow>>1 and cnt ← cnt+1.
  - If cnt==WIDTH-1 at acceptance, go to PAR instead of incrementing.
- PAR:
  - Drive sout_valid=1, sout=par, sout_last=1.
  - On sout_ready: go to IDLE and assert done for exactly one cycle.
- Parity: even. par = XOR of all captured bits, so data bits plus parity bit carry an even count of ones.
- Frame: exactly WIDTH+1 transfers.
- The snapshot is frozen at capture; din changes during a frame have no effect.
- cap while busy (SHIFT or PAR): the request is ignored, overrun ← 1, and the frame continues unchanged. overrun clears only on the next accepted capture in IDLE.
- cap on the same cycle as parity acceptance: state is still PAR, so the request is ignored and overrun is set. No back-to-back frame without one IDLE cycle.
- sout_ready while sout_valid=0 has no effect.
- Backpressure: sout and sout_last stay stable while sout_valid=1 and sout_ready=0.
- Counter: cnt is CW bits, range 0..WIDTH-1, never wraps.

## Timing
- Reset (L=0, asynchronous): state=IDLE; shadow=0; par=0; cnt=0.
- Reset values of outputs: sout=0, sout_valid=0, sout_last=0, busy=0, done=0, overrun=0.
- Release of reset is synchronous to clk. First capture is possible on the first edge with L=1.
- Reset mid-frame aborts immediately. No partial-frame completion and no done pulse.
- Capture latency: cap sampled at edge N gives sout_valid=1 with bit 0 after edge N.
- All outputs are registered or decoded from registered state only. There are no combinational paths from cap or din to any output.
- sout_ready→state is the only combinational input dependency, and it affects next state only.
- With sout_ready held at 1, a frame occupies WIDTH+1 cycles in SHIFT/PAR. done is high on the following cycle, with busy=0 on that same cycle.

## Structure
- Shared package ff_pkg holds:
  - the state enum (IDLE, SHIFT, PAR) and its encoding;
  - the PARITY_EVEN constant.
- The package is reusable by a future ff_loader (serial write side).
- One sub-module, ff_shadow_sreg: WIDTH-bit parallel-load / shift-right register with load and shift enables and a serial LSB output.
- FSM, counter, parity and flags live in the top module.

## Test plan
- WIDTH=8, din=8'hA5, cap pulse, sout_ready=1 → sout sequence 1,0,1,0,0,1,0,1 then parity 0 with sout_last=1. done pulses once; busy is high for 9 cycles.
- din=8'h01 → data bits 1,0,0,0,0,0,0,0 then parity 1. Change din to 8'hFF mid-frame → output unchanged.
- Backpressure: sout_ready toggled 0/1 randomly → sout and sout_last are stable while stalled, exactly 9 accepted transfers, data matches 8'hA5.
- cap asserted at cycle 3 of a frame → frame unaffected and overrun=1. Next cap in IDLE clears overrun and starts a new frame.
- L pulsed low during bit 4 → all outputs 0 immediately, state IDLE, no done pulse. A new cap after release produces a full correct frame.
- cap held high continuously → frames separated by exactly one IDLE cycle, and overrun is set during each frame.
